// File: rtl/pe_shift_acc_pkg.sv
// Shared PE control/config types: SSctl beat control, shift selector and datapath widths.
package pe_shift_acc_pkg;

  localparam int AUODWD  = 16;
  localparam int PSUMDWD = 32;

  typedef enum logic [1:0] {SHT1, SHT2, SHT4, SHT8} ShtNum;

  typedef struct packed {
    logic  valid;
    logic  init;
    logic  fstpix;
    logic  lstpix;
    logic  sht;
    ShtNum sht_num;
  } SSctl;

  // Shift distance selected by ShtNum; shared with PE control.
  function automatic logic [3:0] ShtAmt(input ShtNum n);
    case (n)
      SHT1:    return 4'd1;
      SHT2:    return 4'd2;
      SHT4:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/pe_shift_acc_shift_add.sv
// Combinational base select, barrel shift and sign-extended add for one accumulation beat.
module pe_shift_add
  import pe_shift_acc_pkg::*;
#(
  parameter int AW = pe_shift_acc_pkg::AUODWD,
  parameter int PW = pe_shift_acc_pkg::PSUMDWD
) (
  input  logic          i_init,
  input  logic          i_fstpix,
  input  logic          i_sht,
  input  ShtNum         i_sht_num,
  input  logic [PW-1:0] i_acc,
  input  logic [PW-1:0] i_pbuf,
  input  logic [AW-1:0] i_au,
  output logic [PW-1:0] o_nxt
);

  logic [PW-1:0] w_base;
  logic [PW-1:0] w_shb;
  logic [PW-1:0] w_au_ext;

  assign w_base   = i_init ? (i_fstpix ? '0 : i_pbuf) : i_acc;
  // Bits shifted past the MSB are dropped; the sum wraps modulo 2^PW.
  assign w_shb    = i_sht ? (w_base << ShtAmt(i_sht_num)) : w_base;
  assign w_au_ext = {{(PW-AW){i_au[AW-1]}}, i_au};
  assign o_nxt    = w_shb + w_au_ext;

endmodule

// File: rtl/pe_shift_acc.sv
// Shift-accumulate stage: builds a psum from Aunit beats and emits it over valid/ready on lstpix.
module pe_shift_acc
  import pe_shift_acc_pkg::*;
#(
  parameter int AUODWD  = pe_shift_acc_pkg::AUODWD,
  parameter int PSUMDWD = pe_shift_acc_pkg::PSUMDWD,
  parameter int CNTWD   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  SSctl               i_ssctl,
  input  logic [AUODWD-1:0]  i_au,
  input  logic [PSUMDWD-1:0] i_pbuf,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [PSUMDWD-1:0] o_psum,
  output logic [CNTWD-1:0]   o_beats,
  output logic               o_err
);

  logic [PSUMDWD-1:0] r_acc;
  logic [PSUMDWD-1:0] r_psum;
  logic [CNTWD-1:0]   r_beats;
  logic               r_valid;
  logic               r_active;
  logic               r_err;

  logic [PSUMDWD-1:0] w_nxt;
  logic [CNTWD-1:0]   w_beats_nxt;
  logic               w_take;
  logic               w_proto_err;

  pe_shift_add #(.AW(AUODWD), .PW(PSUMDWD)) u_shift_add (
    .i_init    (i_ssctl.init),
    .i_fstpix  (i_ssctl.fstpix),
    .i_sht     (i_ssctl.sht),
    .i_sht_num (i_ssctl.sht_num),
    .i_acc     (r_acc),
    .i_pbuf    (i_pbuf),
    .i_au      (i_au),
    .o_nxt     (w_nxt)
  );

  // Single output register without skid: accept only when it is empty or draining.
  assign o_ready     = !r_valid || i_ready;
  assign w_take      = i_valid && o_ready && i_ssctl.valid;
  assign w_beats_nxt = i_ssctl.init ? CNTWD'(1) : ((&r_beats) ? r_beats : r_beats + 1'b1);
  assign w_proto_err = (!i_ssctl.init && !r_active) ||
                       (i_ssctl.init && r_active) ||
                       (i_ssctl.fstpix && !i_ssctl.init);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_psum   <= '0;
      r_beats  <= '0;
      r_valid  <= 1'b0;
      r_active <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (r_valid && i_ready) r_valid <= 1'b0;
      if (w_take) begin
        r_beats <= w_beats_nxt;
        if (w_proto_err) r_err <= 1'b1;
        if (i_ssctl.lstpix) begin
          r_psum   <= w_nxt;
          r_valid  <= 1'b1;
          r_acc    <= '0;
          r_active <= 1'b0;
        end else begin
          r_acc    <= w_nxt;
          r_active <= 1'b1;
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_psum  = r_psum;
  assign o_beats = r_beats;
  assign o_err   = r_err;

endmodule

// File: tb/tb_pe_shift_acc.sv
// Scoreboard bench for pe_shift_acc: directed scenarios plus randomized accumulations vs a reference model.
module tb_pe_shift_acc;
  import pe_shift_acc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid;
  logic        o_ready;
  SSctl        i_ssctl;
  logic [15:0] i_au;
  logic [31:0] i_pbuf;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_psum;
  logic [7:0]  o_beats;
  logic        o_err;

  always #5 clk = ~clk;

  pe_shift_acc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_ssctl (i_ssctl),
    .i_au    (i_au),
    .i_pbuf  (i_pbuf),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_psum  (o_psum),
    .o_beats (o_beats),
    .o_err   (o_err)
  );

  typedef struct {
    logic [31:0] psum;
    logic [7:0]  beats;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_acc;
  bit          m_active;
  int          m_beats;
  bit          m_err;
  bit          rand_rdy;
  int unsigned sht_tbl[4] = '{1, 2, 4, 8};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic SSctl mk(input bit v, input bit init, input bit fst, input bit lst,
                              input bit sht, input ShtNum n);
    SSctl s;
    s.valid = v; s.init = init; s.fstpix = fst; s.lstpix = lst; s.sht = sht; s.sht_num = n;
    return s;
  endfunction

  function automatic void model_reset();
    m_acc = '0; m_active = 0; m_beats = 0; m_err = 0;
    sb.delete();
  endfunction

  // Reference: psum = base * 2^shift + au (signed), modulo 2^32.
  function automatic void model_beat(input SSctl s, input logic [15:0] au, input logic [31:0] pbuf);
    logic [31:0] base, nxt;
    int          au_i;
    exp_t        e;
    if (!s.valid) return;
    au_i = $signed(au);
    base = s.init ? (s.fstpix ? 32'd0 : pbuf) : m_acc;
    if (s.sht) base = base * (32'd1 << sht_tbl[int'(s.sht_num)]);
    nxt = base + au_i;
    if ((!s.init && !m_active) || (s.init && m_active) || (s.fstpix && !s.init)) m_err = 1;
    m_beats = s.init ? 1 : ((m_beats >= 255) ? 255 : m_beats + 1);
    if (s.lstpix) begin
      e.psum = nxt; e.beats = 8'(m_beats);
      sb.push_back(e);
      m_acc = '0; m_active = 0;
    end else begin
      m_acc = nxt; m_active = 1;
    end
  endfunction

  task automatic send(input SSctl s, input logic [15:0] au, input logic [31:0] pbuf);
    bit took = 0;
    i_valid = 1'b1; i_ssctl = s; i_au = au; i_pbuf = pbuf;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (o_ready) begin took = 1; break; end
      @(posedge clk); #1;
      if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
    end
    if (!took) begin
      checks++; failures++;
      $display("FAIL handshake_timeout actual=no_accept required=accept");
    end else begin
      @(posedge clk); #1;
      model_beat(s, au, pbuf);
    end
    i_valid = 1'b0;
    if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output actual=0x%0h required=none", o_psum);
        end else begin
          e = sb.pop_front();
          check("sb_psum", o_psum, e.psum);
          check("sb_beats", 32'(o_beats), 32'(e.beats));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    time t0;
    int  len;
    i_valid = 0; i_ready = 1; rand_rdy = 0; i_ssctl = '0; i_au = '0; i_pbuf = '0;
    model_reset();
    #12;
    check("rst_valid", 32'(o_valid), 0);
    check("rst_ready", 32'(o_ready), 1);
    check("rst_psum", o_psum, 0);
    check("rst_beats", 32'(o_beats), 0);
    check("rst_err", 32'(o_err), 0);
    @(negedge clk); rst_n = 1;
    tick(1);

    // Reset mid-accumulation
    send(mk(1, 1, 1, 0, 0, SHT1), 16'h55, 0);
    #2 rst_n = 0;
    model_reset();
    #2;
    check("midrst_psum", o_psum, 0);
    check("midrst_valid", 32'(o_valid), 0);
    check("midrst_beats", 32'(o_beats), 0);
    check("midrst_err", 32'(o_err), 0);
    @(negedge clk); rst_n = 1;
    tick(1);
    send(mk(1, 1, 1, 1, 0, SHT1), 16'd2, 0);
    check("postrst_psum", o_psum, 32'd2);
    tick(2);
    check("postrst_err", 32'(o_err), 0);

    // Bit-serial
    send(mk(1, 1, 1, 0, 0, SHT1), 16'd1, 0);
    send(mk(1, 0, 0, 0, 1, SHT1), 16'd0, 0);
    send(mk(1, 0, 0, 0, 1, SHT1), 16'd1, 0);
    send(mk(1, 0, 0, 1, 1, SHT1), 16'd1, 0);
    check("bitser_psum", o_psum, 32'hB);
    check("bitser_beats", 32'(o_beats), 4);
    tick(2);

    // Buffer init with SHT8 and negative au
    send(mk(1, 1, 0, 1, 1, SHT8), 16'hFFFF, 32'h100);
    check("pbuf_psum", o_psum, 32'h0000FFFF);
    tick(2);

    // Backpressure
    i_ready = 0;
    send(mk(1, 1, 1, 1, 0, SHT1), 16'd9, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_ready", 32'(o_ready), 0);
      check("bp_valid", 32'(o_valid), 1);
      check("bp_psum", o_psum, 32'd9);
    end
    @(posedge clk); #1;
    i_ready = 1;
    t0 = $time;
    send(mk(1, 1, 1, 1, 0, SHT1), 16'd4, 0);
    check("bp_release_latency", 32'($time - t0), 32'd10);
    tick(2);

    // Back-to-back single-term outputs
    for (int k = 0; k < 3; k++) begin
      t0 = $time;
      send(mk(1, 1, 1, 1, 0, SHT1), 16'(3 + 2 * k), 0);
      check("b2b_cycle", 32'($time - t0), 32'd10);
      check("b2b_valid", 32'(o_valid), 1);
      check("b2b_psum", o_psum, 32'(3 + 2 * k));
    end
    tick(2);

    // Randomized accumulations with bubbles and random backpressure
    rand_rdy = 1;
    for (int a = 0; a < 40; a++) begin
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 4) == 0)
          send(mk(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  ShtNum'($urandom_range(0, 3))), 16'($urandom), $urandom);
        send(mk(1, b == 0, (b == 0) && 1'($urandom_range(0, 1)), b == len - 1,
                1'($urandom_range(0, 1)), ShtNum'($urandom_range(0, 3))),
             16'($urandom), $urandom);
      end
    end
    rand_rdy = 0;
    i_ready = 1;
    tick(3);
    check("rand_err", 32'(o_err), 32'(m_err));

    // Beat counter saturation
    send(mk(1, 1, 1, 0, 0, SHT1), 16'($urandom), 0);
    for (int b = 1; b < 260; b++)
      send(mk(1, 0, 0, b == 259, 0, SHT1), 16'($urandom), 0);
    check("sat_beats", 32'(o_beats), 32'd255);
    tick(2);

    // Protocol error and wrap-around
    send(mk(1, 0, 0, 0, 0, SHT1), 16'd1, 0);
    check("err_set", 32'(o_err), 1);
    send(mk(1, 0, 0, 1, 0, SHT1), 16'd1, 0);
    send(mk(1, 1, 0, 0, 0, SHT1), 16'd0, 32'h7FFFFFFF);
    send(mk(1, 0, 0, 1, 0, SHT1), 16'd1, 0);
    check("wrap_psum", o_psum, 32'h80000000);
    tick(5);
    check("err_sticky", 32'(o_err), 1);
    check("err_model", 32'(o_err), 32'(m_err));

    for (int w = 0; w < 100 && sb.size() != 0; w++) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
